// File: rtl/chunked_adder_seq_pkg.sv
// Shared constants for the chunked adder sequencer: default sizes,
// FSM state encoding and a helper for the chunk index width.
package chunked_adder_seq_pkg;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_CHUNK_WIDTH = 8;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_BUSY = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    // Index register is clog2(chunks) wide but never narrower than one bit.
    function automatic int idx_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/chunked_adder_seq_if.sv
// Operand/result handshake bundle: valid/ready operand input, valid/ready sum output.
interface chunked_adder_seq_if
    import chunked_adder_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;

    // master: producer/consumer side; slave: the adder sequencer.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum
    );

endinterface

// File: rtl/chunked_adder_seq_chunk_adder.sv
// Narrow ripple-carry slice built from full_adder cells, with explicit
// carry-in and carry-out so it can be chained across cycles.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);
    logic w_p;

    assign w_p     = i_a ^ i_b;
    assign o_sum   = w_p ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & w_p);
endmodule

module chunk_adder
    import chunked_adder_seq_pkg::*;
#(
    parameter int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
    input  logic [CHUNK_WIDTH-1:0] i_a,
    input  logic [CHUNK_WIDTH-1:0] i_b,
    input  logic                   i_carry,
    output logic [CHUNK_WIDTH-1:0] o_sum,
    output logic                   o_carry
);
    logic [CHUNK_WIDTH:0] w_carry;

    assign w_carry[0] = i_carry;
    assign o_carry    = w_carry[CHUNK_WIDTH];

    for (genvar g = 0; g < CHUNK_WIDTH; g++) begin : g_bit
        full_adder u_fa (
            .i_a     (i_a[g]),
            .i_b     (i_b[g]),
            .i_c     (w_carry[g]),
            .o_sum   (o_sum[g]),
            .o_carry (w_carry[g+1])
        );
    end
endmodule

// File: rtl/chunked_adder_seq.sv
// Multi-cycle WIDTH-bit adder: one CHUNK_WIDTH slice reused per cycle,
// LSB chunk first, carry held in a register between chunks.
//
// state      | meaning
// STATE_IDLE | waiting for operands, in_ready high
// STATE_BUSY | adding one chunk per cycle
// STATE_DONE | sum presented, waiting for out_ready
module chunked_adder_seq
    import chunked_adder_seq_pkg::*;
#(
    parameter  int WIDTH       = DEFAULT_WIDTH,
    parameter  int CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH,
    localparam int NUM_CHUNKS  = WIDTH / CHUNK_WIDTH,
    localparam int IDX_W       = idx_width(NUM_CHUNKS)
) (
    input  logic               clk,
    input  logic               rst,
    chunked_adder_seq_if.slave bus
);

    if ((CHUNK_WIDTH < 1) || (WIDTH % CHUNK_WIDTH != 0)) begin : g_bad_width
        $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK_WIDTH");
    end

    logic [1:0]             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_carry;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH:0]         r_sum;
    logic                   r_out_valid;

    logic [CHUNK_WIDTH-1:0] w_a_chunk;
    logic [CHUNK_WIDTH-1:0] w_b_chunk;
    logic [CHUNK_WIDTH-1:0] w_slice_sum;
    logic                   w_slice_carry;
    logic                   w_last;

    assign w_a_chunk = r_a[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign w_b_chunk = r_b[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign w_last    = (r_idx == IDX_W'(NUM_CHUNKS - 1));

    chunk_adder #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_slice (
        .i_a     (w_a_chunk),
        .i_b     (w_b_chunk),
        .i_carry (r_carry),
        .o_sum   (w_slice_sum),
        .o_carry (w_slice_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= STATE_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_state <= STATE_BUSY;
                    end
                end
                STATE_BUSY: begin
                    r_sum[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_slice_sum;
                    r_carry <= w_slice_carry;
                    if (w_last) begin
                        r_sum[WIDTH] <= w_slice_carry;
                        r_idx        <= '0;
                        r_out_valid  <= 1'b1;
                        r_state      <= STATE_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                STATE_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idx       <= '0;
                        r_state     <= STATE_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= STATE_IDLE;
                end
            endcase
        end
    end

    // in_ready is a pure state decode, masked while reset is held.
    assign bus.in_ready  = (r_state == STATE_IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Randomized self-checking bench for chunked_adder_seq against a plain a+b model.
module tb_chunked_adder_seq;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    chunked_adder_seq_if #(.WIDTH(W)) bus ();

    chunked_adder_seq #(
        .WIDTH       (W),
        .CHUNK_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // One transaction; stall = cycles out_ready is held low once the sum is presented.
    task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int stall, input string tag);
        logic [W:0] exp;
        int         lat;
        exp = model_sum(ta, tb_v);
        @(negedge clk);
        bus.a         = ta;
        bus.b         = tb_v;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        check({tag, " in_ready before accept"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        check({tag, " in_ready busy"}, bus.in_ready, 0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 4);
        check({tag, " sum"}, bus.sum, exp);
        check({tag, " in_ready done"}, bus.in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk); #1;
            check({tag, " stall out_valid"}, bus.out_valid, 1);
            check({tag, " stall sum"}, bus.sum, exp);
            check({tag, " stall in_ready"}, bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " out_valid after handshake"}, bus.out_valid, 0);
        check({tag, " in_ready after handshake"}, bus.in_ready, 1);
    endtask

    // Accept random operands, wait some edges, then pulse reset off the clock edge.
    task automatic reset_mid(input int wait_edges, input bit in_done, input string tag);
        @(negedge clk);
        bus.a         = $urandom | 32'h0101_0101;
        bus.b         = $urandom;
        bus.in_valid  = 1'b1;
        bus.out_ready = !in_done;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (wait_edges) @(posedge clk);
        #2;
        check({tag, " out_valid before reset"}, bus.out_valid, in_done);
        #1 rst = 1'b1;
        #1;
        check({tag, " out_valid in reset"}, bus.out_valid, 0);
        check({tag, " sum in reset"}, bus.sum, 0);
        check({tag, " in_ready in reset"}, bus.in_ready, 0);
        #7 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " in_ready after reset"}, bus.in_ready, 1);
        check({tag, " out_valid after reset"}, bus.out_valid, 0);
    endtask

    task automatic stream_test(input int n_txn);
        logic [W:0] exp_q[$];
        logic [W:0] exp;
        int         got;
        int         cyc;
        int         last_acc;
        got      = 0;
        last_acc = -1;
        bus.out_ready = 1'b1;
        for (cyc = 0; cyc < 400 && got < n_txn; cyc++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            if (bus.in_ready) begin
                exp_q.push_back(model_sum(bus.a, bus.b));
                if (last_acc >= 0) check("stream accept spacing", cyc - last_acc, 6);
                last_acc = cyc;
            end
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream unexpected result", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("stream sum", bus.sum, exp);
                end
                got++;
            end
        end
        check("stream results received", got, n_txn);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        #3;
        check("reset in_ready", bus.in_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset sum", bus.sum, 0);
        #20 rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset in_ready", bus.in_ready, 1);
        check("post-reset out_valid", bus.out_valid, 0);

        do_txn(32'd1, 32'd2, 0, "t1");
        check("t1 model", model_sum(32'd1, 32'd2), 33'h0_0000_0003);
        do_txn(32'hFFFF_FFFF, 32'h0000_0001, 0, "t2 full carry");
        do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "t3 max");
        do_txn(32'h1234_5678, 32'h8765_4321, 0, "t3 pattern");
        do_txn($urandom, $urandom, 5, "t4 stall");

        reset_mid(2, 1'b0, "t5 busy");
        do_txn(32'd5, 32'd7, 0, "t5 after reset");
        reset_mid(5, 1'b1, "t5 done");
        do_txn(32'h0000_FFFF, 32'h0000_0001, 0, "t5 after done reset");

        for (int i = 0; i < 10; i++) begin
            do_txn($urandom, $urandom, $urandom_range(0, 3), "rand");
        end

        stream_test(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
